regwrite_tracer: RTL and testbench
==================================

# regwrite_tracer

Downstream consumer of the processor core's register-write port (DONE, OUTADDR, OUTDATA, OUTVALID). Every register write is captured with a 16-bit cycle stamp into a trace FIFO and drained over a valid/ready stream. A 32×32 shadow register file and a running checksum are kept for end-of-program checks. It asserts FINISHED once the core reports DONE and the trace has fully drained.

## Interface
- DEPTH, 16: trace FIFO entries, power of 2, ≥2
- CK  in  1  clock, rising edge
- RESET  in  1  reset; synchronous, active-low
- DONE_IN  in  1  core program-complete
- WVALID  in  1  core register write strobe
- WADDR  in  5  written register index
- WDATA  in  32  written value
- T_VALID  out  1  trace entry available
- T_READY  in  1  trace sink accepts
- T_STAMP  out  16  cycle stamp of head entry
- T_ADDR  out  5  address of head entry
- T_DATA  out  32  data of head entry
- RD_ADDR  in  5  shadow read index
- RD_DATA  out  32  shadow[RD_ADDR], combinational
- CHECKSUM  out  32  running write checksum
- WCOUNT  out  16  accepted writes, saturating at 0xFFFF
- DROPPED  out  8  writes lost to full FIFO, saturating at 0xFF
- OVERFLOW  out  1  sticky, set on first drop
- FINISHED  out  1  done and drained

## Operation
- Reset (RESET=0 at an edge): FIFO empty, stamp=0, shadow all 0, CHECKSUM=0, WCOUNT=0, DROPPED=0, OVERFLOW=0, FINISHED=0, state=RUN. T_VALID=0 and T_STAMP/T_ADDR/T_DATA=0 while empty.
- Stamp counter: +1 every non-reset cycle. Wraps 0xFFFF→0x0000. The first cycle after release stamps 0.
- States:
  - RUN: capture writes. DONE_IN=1 → FLUSH. A write in the same cycle as DONE_IN is still captured.
  - FLUSH: WVALID ignored. Drain continues. FIFO empty → FINISHED.
  - FINISHED: FINISHED=1. Held until reset.
- Capture (RUN & WVALID):
  - Not full: push {stamp, WADDR, WDATA}.
  - Full: drop the entry, DROPPED+1 (saturating), OVERFLOW←1.
  - Shadow, CHECKSUM and WCOUNT update on every capture, dropped or not.
- Shadow: shadow[WADDR]←WDATA, except address 0, which stays 0.
- Checksum: CHECKSUM ← rotl1(CHECKSUM) ^ WDATA ^ {27'b0, WADDR}.
- Drain: a pop occurs when T_VALID & T_READY at an edge.
- Full with simultaneous push and pop: both occur, occupancy unchanged, no drop.
- Empty with push: T_READY is irrelevant that cycle; there is no bypass.
- Reset mid-operation: all state is discarded immediately, including pending FIFO entries.

## Timing
- Capture latency: a write sampled at edge k sets T_VALID from after edge k (cycle k+1). Head fields are registered and stable while T_VALID=1 and T_READY=0.
- Sustained throughput: 1 write/cycle in, 1 entry/cycle out.
- FINISHED rises the cycle after the edge where FLUSH observes the FIFO empty. Minimum is 2 edges after DONE_IN with an empty FIFO.
- RD_DATA reflects a shadow write from the following cycle; it is not forwarded.
- CHECKSUM, WCOUNT and DROPPED are registered and update the cycle after capture.

## Structure
- Shared package `tracer_pkg`:
  - entry struct {stamp[15:0], addr[4:0], data[31:0]} (53 bits)
  - state enum {RUN, FLUSH, FINISHED}
  - STAMP_W=16, ADDR_W=5, DATA_W=32
- Sub-module `trace_fifo`: synchronous FIFO, parameter DEPTH, registered head output, full/empty. It contains no bypass path.
- Top level holds the FSM, stamp counter, shadow array, checksum and counters.

## Test plan
- Reset, then write (3, 0x00000010) at stamp 2 and (1, 0x80000000) at stamp 3, T_READY=1 → entries (0002,03,00000010) and (0003,01,80000000) in order. CHECKSUM=0x80000027. RD_ADDR=3 → 0x00000010. WCOUNT=2.
- Write (0, 0xDEADBEEF) → entry is traced. RD_DATA at address 0 stays 0x00000000. CHECKSUM=0xDEADBEEF.
- T_READY=0, 20 consecutive writes with DEPTH=16 → 16 entries retained, DROPPED=4, OVERFLOW=1. Then raise T_READY → exactly the first 16 writes are drained, in order.
- FIFO full, T_READY=1, WVALID=1 for 10 cycles → DROPPED=0, in-order stream with no gaps.
- 5 entries queued with T_READY=0, DONE_IN pulsed, then write attempts → later writes are ignored. Raise T_READY → FINISHED=1 one cycle after the 5th pop. FINISHED stays high under further stimulus.
- Run 0x10002 cycles with a write at the end → stamp wraps to 0x0001. Assert RESET=0 mid-drain → next cycle T_VALID=0, all counters 0.

Source files
------------

// File: rtl/tracer_pkg.sv
// Shared types and helpers for the register-write tracer.
package tracer_pkg;

  localparam int STAMP_W = 16;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;

  // One trace record: cycle stamp, register index, written value (53 bits).
  typedef struct packed {
    logic [STAMP_W-1:0] stamp;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
  } entry_t;

  // Prefixed so the members cannot collide with the FINISHED port name.
  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_FLUSH    = 2'd1,
    S_FINISHED = 2'd2
  } state_t;

  // Rotate left by one bit, used by the running checksum.
  function automatic logic [DATA_W-1:0] rotl1(input logic [DATA_W-1:0] v);
    return {v[DATA_W-2:0], v[DATA_W-1]};
  endfunction

endpackage

// File: rtl/regwrite_tracer_if.sv
// Core write port plus trace stream, bundled as one interface.
// master = core/sink side, slave = the tracer.
interface regwrite_tracer_if;
  import tracer_pkg::*;

  logic                DONE_IN;
  logic                WVALID;
  logic [ADDR_W-1:0]   WADDR;
  logic [DATA_W-1:0]   WDATA;
  logic                T_VALID;
  logic                T_READY;
  logic [STAMP_W-1:0]  T_STAMP;
  logic [ADDR_W-1:0]   T_ADDR;
  logic [DATA_W-1:0]   T_DATA;

  modport master (
    output DONE_IN, WVALID, WADDR, WDATA, T_READY,
    input  T_VALID, T_STAMP, T_ADDR, T_DATA
  );

  modport slave (
    input  DONE_IN, WVALID, WADDR, WDATA, T_READY,
    output T_VALID, T_STAMP, T_ADDR, T_DATA
  );

endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace entries. The head is read from the storage
// registers and forced to zero while empty; there is no write-to-head bypass.
module trace_fifo
  import tracer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   CK,
  input  logic   RESET,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   empty_o,
  output logic   full_o
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;

  // Storage write; stale contents are never visible because the head is gated by empty.
  always_ff @(posedge CK) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer and occupancy registers; reset discards every pending entry.
  always_ff @(posedge CK) begin
    if (!RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Occupancy next-state: simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/regwrite_tracer.sv
// Register-write tracer: stamps and queues core register writes, keeps a
// shadow register file and checksum, and flags completion once drained.
module regwrite_tracer
  import tracer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                CK,
  input  logic                RESET,
  regwrite_tracer_if.slave    bus,
  input  logic [ADDR_W-1:0]   RD_ADDR,
  output logic [DATA_W-1:0]   RD_DATA,
  output logic [DATA_W-1:0]   CHECKSUM,
  output logic [15:0]         WCOUNT,
  output logic [7:0]          DROPPED,
  output logic                OVERFLOW,
  output logic                FINISHED
);

  state_t             state_q, state_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic [DATA_W-1:0]  chk_q, chk_d;
  logic [15:0]        wcount_q, wcount_d;
  logic [7:0]         dropped_q, dropped_d;
  logic               ovf_q, ovf_d;
  logic [DATA_W-1:0]  shadow_q [32];

  logic   capture, push, pop, drop;
  logic   fifo_empty, fifo_full;
  entry_t head, new_entry;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign capture   = (state_q == S_RUN) && bus.WVALID;
  assign pop       = !fifo_empty && bus.T_READY;
  assign push      = capture && (!fifo_full || pop);
  assign drop      = capture && fifo_full && !pop;
  assign new_entry = '{stamp: stamp_q, addr: bus.WADDR, data: bus.WDATA};

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CK          (CK),
    .RESET       (RESET),
    .push_i      (push),
    .push_data_i (new_entry),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign bus.T_VALID = !fifo_empty;
  assign bus.T_STAMP = head.stamp;
  assign bus.T_ADDR  = head.addr;
  assign bus.T_DATA  = head.data;

  // FSM state register.
  always_ff @(posedge CK) begin
    if (!RESET) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // FSM next state and FINISHED decode.
  always_comb begin
    state_d  = state_q;
    FINISHED = 1'b0;
    case (state_q)
      S_RUN:      if (bus.DONE_IN) state_d = S_FLUSH;
      S_FLUSH:    if (fifo_empty)  state_d = S_FINISHED;
      S_FINISHED: FINISHED = 1'b1;
      default:    state_d = S_RUN;
    endcase
  end

  // Next-state for the stamp, checksum and saturating counters.
  always_comb begin
    stamp_d   = stamp_q + 1'b1;
    chk_d     = chk_q;
    wcount_d  = wcount_q;
    dropped_d = dropped_q;
    ovf_d     = ovf_q | drop;
    if (capture) begin
      chk_d = rotl1(chk_q) ^ bus.WDATA ^ {{(DATA_W - ADDR_W){1'b0}}, bus.WADDR};
      if (wcount_q != 16'hFFFF) wcount_d = wcount_q + 1'b1;
    end
    if (drop && dropped_q != 8'hFF) dropped_d = dropped_q + 1'b1;
  end

  // Stamp, checksum and counter registers.
  always_ff @(posedge CK) begin
    if (!RESET) begin
      stamp_q   <= '0;
      chk_q     <= '0;
      wcount_q  <= '0;
      dropped_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      stamp_q   <= stamp_d;
      chk_q     <= chk_d;
      wcount_q  <= wcount_d;
      dropped_q <= dropped_d;
      ovf_q     <= ovf_d;
    end
  end

  // Shadow register file; index 0 is hardwired to zero like the core's r0.
  always_ff @(posedge CK) begin
    if (!RESET) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
    end else if (capture && bus.WADDR != '0) begin
      shadow_q[bus.WADDR] <= bus.WDATA;
    end
  end

  assign RD_DATA  = shadow_q[RD_ADDR];
  assign CHECKSUM = chk_q;
  assign WCOUNT   = wcount_q;
  assign DROPPED  = dropped_q;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_regwrite_tracer.sv
// Directed bench for regwrite_tracer with hand-computed expectations.
module tb_regwrite_tracer;
  import tracer_pkg::*;

  logic        CK;
  logic        RESET;
  logic [4:0]  RD_ADDR;
  logic [31:0] RD_DATA;
  logic [31:0] CHECKSUM;
  logic [15:0] WCOUNT;
  logic [7:0]  DROPPED;
  logic        OVERFLOW;
  logic        FINISHED;

  int total = 0;
  int bad   = 0;

  regwrite_tracer_if bus ();

  regwrite_tracer #(.DEPTH(16)) dut (
    .CK       (CK),
    .RESET    (RESET),
    .bus      (bus),
    .RD_ADDR  (RD_ADDR),
    .RD_DATA  (RD_DATA),
    .CHECKSUM (CHECKSUM),
    .WCOUNT   (WCOUNT),
    .DROPPED  (DROPPED),
    .OVERFLOW (OVERFLOW),
    .FINISHED (FINISHED)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CK);
    #1;
  endtask

  task automatic do_reset;
    RESET         = 1'b0;
    bus.DONE_IN   = 1'b0;
    bus.WVALID    = 1'b0;
    bus.WADDR     = '0;
    bus.WDATA     = '0;
    bus.T_READY   = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
  endtask

  task automatic set_wr(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.WVALID = v;
    bus.WADDR  = a;
    bus.WDATA  = d;
  endtask

  initial begin
    RD_ADDR = 5'd3;

    // ---- reset state
    do_reset();
    check_eq("rst_tvalid", bus.T_VALID, 0);
    check_eq("rst_tstamp", bus.T_STAMP, 0);
    check_eq("rst_tdata", bus.T_DATA, 0);
    check_eq("rst_checksum", CHECKSUM, 0);
    check_eq("rst_wcount", WCOUNT, 0);
    check_eq("rst_dropped", DROPPED, 0);
    check_eq("rst_overflow", OVERFLOW, 0);
    check_eq("rst_finished", FINISHED, 0);
    check_eq("rst_rddata", RD_DATA, 0);

    // ---- two writes at stamps 2 and 3, sink always ready
    bus.T_READY = 1'b1;
    tick();
    tick();
    set_wr(1'b1, 5'd3, 32'h0000_0010);
    tick();
    check_eq("t1_valid0", bus.T_VALID, 1);
    check_eq("t1_stamp0", bus.T_STAMP, 16'h0002);
    check_eq("t1_addr0", bus.T_ADDR, 5'd3);
    check_eq("t1_data0", bus.T_DATA, 32'h0000_0010);
    check_eq("t1_rd3", RD_DATA, 32'h0000_0010);
    set_wr(1'b1, 5'd1, 32'h8000_0000);
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    check_eq("t1_stamp1", bus.T_STAMP, 16'h0003);
    check_eq("t1_addr1", bus.T_ADDR, 5'd1);
    check_eq("t1_data1", bus.T_DATA, 32'h8000_0000);
    check_eq("t1_checksum", CHECKSUM, 32'h8000_0027);
    check_eq("t1_wcount", WCOUNT, 2);
    tick();
    check_eq("t1_empty", bus.T_VALID, 0);
    check_eq("t1_empty_data", bus.T_DATA, 0);

    // ---- write to r0: traced, shadow stays zero
    do_reset();
    RD_ADDR = 5'd0;
    set_wr(1'b1, 5'd0, 32'hDEAD_BEEF);
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    check_eq("t2_valid", bus.T_VALID, 1);
    check_eq("t2_addr", bus.T_ADDR, 0);
    check_eq("t2_data", bus.T_DATA, 32'hDEAD_BEEF);
    check_eq("t2_rd0", RD_DATA, 0);
    check_eq("t2_checksum", CHECKSUM, 32'hDEAD_BEEF);
    check_eq("t2_wcount", WCOUNT, 1);

    // ---- 20 writes into a stalled FIFO: 16 kept, 4 dropped
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_wr(1'b1, 5'(i), 32'h1000 + 32'(i));
      tick();
    end
    set_wr(1'b0, 5'd0, 32'h0);
    check_eq("t3_dropped", DROPPED, 4);
    check_eq("t3_overflow", OVERFLOW, 1);
    check_eq("t3_wcount", WCOUNT, 20);
    tick();
    tick();
    check_eq("t3_head_stable", bus.T_DATA, 32'h1000);
    bus.T_READY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq("t3_drain_data", bus.T_DATA, 32'h1000 + 32'(i));
      check_eq("t3_drain_stamp", bus.T_STAMP, 16'(i));
      tick();
    end
    check_eq("t3_drained", bus.T_VALID, 0);

    // ---- full FIFO with simultaneous push and pop: no drops, no gaps
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_wr(1'b1, 5'd2, 32'h2000 + 32'(i));
      tick();
    end
    bus.T_READY = 1'b1;
    for (int j = 0; j < 10; j++) begin
      set_wr(1'b1, 5'd2, 32'h2010 + 32'(j));
      check_eq("t4_stream", bus.T_DATA, 32'h2000 + 32'(j));
      tick();
    end
    set_wr(1'b0, 5'd0, 32'h0);
    for (int k = 10; k < 26; k++) begin
      check_eq("t4_tail", bus.T_DATA, 32'h2000 + 32'(k));
      tick();
    end
    check_eq("t4_empty", bus.T_VALID, 0);
    check_eq("t4_dropped", DROPPED, 0);
    check_eq("t4_overflow", OVERFLOW, 0);
    check_eq("t4_wcount", WCOUNT, 26);

    // ---- DONE with 5 queued entries, later writes ignored
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_wr(1'b1, 5'd4, 32'h3000 + 32'(i));
      tick();
    end
    set_wr(1'b0, 5'd0, 32'h0);
    bus.DONE_IN = 1'b1;
    tick();
    bus.DONE_IN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_wr(1'b1, 5'd4, 32'h0000_0BAD);
      tick();
    end
    set_wr(1'b0, 5'd0, 32'h0);
    check_eq("t5_wcount_frozen", WCOUNT, 5);
    check_eq("t5_not_finished", FINISHED, 0);
    bus.T_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("t5_drain", bus.T_DATA, 32'h3000 + 32'(i));
      tick();
    end
    check_eq("t5_empty", bus.T_VALID, 0);
    check_eq("t5_fin_early", FINISHED, 0);
    tick();
    check_eq("t5_finished", FINISHED, 1);
    bus.DONE_IN = 1'b1;
    set_wr(1'b1, 5'd5, 32'h5555_5555);
    tick();
    bus.DONE_IN = 1'b0;
    tick();
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    check_eq("t5_fin_held", FINISHED, 1);
    check_eq("t5_no_capture", bus.T_VALID, 0);
    check_eq("t5_wcount_held", WCOUNT, 5);

    // ---- DROPPED saturates at 0xFF
    do_reset();
    for (int i = 0; i < 276; i++) begin
      set_wr(1'b1, 5'd7, 32'(i));
      tick();
    end
    set_wr(1'b0, 5'd0, 32'h0);
    check_eq("t6_dropped_sat", DROPPED, 8'hFF);
    check_eq("t6_wcount", WCOUNT, 276);
    check_eq("t6_head", bus.T_DATA, 0);

    // ---- stamp wrap, then reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 32'h10001; i++) tick();
    set_wr(1'b1, 5'd9, 32'hCAFE_0000);
    tick();
    for (int i = 1; i < 4; i++) begin
      set_wr(1'b1, 5'd9, 32'hCAFE_0000 + 32'(i));
      tick();
    end
    set_wr(1'b0, 5'd0, 32'h0);
    check_eq("t7_wrap_stamp", bus.T_STAMP, 16'h0001);
    bus.T_READY = 1'b1;
    tick();
    check_eq("t7_mid_drain", bus.T_DATA, 32'hCAFE_0001);
    RESET = 1'b0;
    tick();
    check_eq("t7_rst_tvalid", bus.T_VALID, 0);
    check_eq("t7_rst_wcount", WCOUNT, 0);
    check_eq("t7_rst_checksum", CHECKSUM, 0);
    check_eq("t7_rst_stamp", bus.T_STAMP, 0);
    RESET = 1'b1;
    bus.T_READY = 1'b0;
    set_wr(1'b1, 5'd1, 32'h1);
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    check_eq("t7_post_rst_stamp", bus.T_STAMP, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
